// File: rtl/divclk_pkg.sv
// Shared constants and types for the DDS clock-divider controller.
package divclk_pkg;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned CHW = 2;

  typedef logic [CHW-1:0] chan_t;
  typedef logic [DW-1:0]  ratio_t;

  // A ratio of zero parks the channel with ce and out_clk held low.
  localparam ratio_t DIV_OFF = '0;

endpackage

// File: rtl/divclk_chan.sv
// One divider channel: counter, active/pending ratio, ce pulse and 50% divided clock.
module divclk_chan
  import divclk_pkg::*;
#(
  parameter ratio_t RST_DIV = ratio_t'(2)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  ratio_t load_div,
  output logic   pend,
  output logic   ce,
  output logic   out_clk
);

  ratio_t r_cnt;
  ratio_t r_div;
  ratio_t r_pdiv;
  logic   r_pend;
  logic   r_ce;
  logic   r_out_clk;

  logic   w_off;
  logic   w_wrap;

  // Period-boundary detect; an off channel never wraps.
  always_comb begin
    w_off  = (r_div == DIV_OFF);
    w_wrap = !w_off && (r_cnt == r_div - ratio_t'(1));
  end

  // Counter, pending-ratio capture and boundary-aligned ratio apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_div     <= RST_DIV;
      r_pdiv    <= '0;
      r_pend    <= 1'b0;
      r_ce      <= 1'b0;
      r_out_clk <= 1'b0;
    end else begin
      // load only arrives while r_pend is low, so it never races the clear below
      if (load) begin
        r_pdiv <= load_div;
        r_pend <= 1'b1;
      end
      if (w_off) begin
        r_cnt     <= '0;
        r_ce      <= 1'b0;
        r_out_clk <= 1'b0;
        if (r_pend) begin
          r_div  <= r_pdiv;
          r_pend <= 1'b0;
        end
      end else if (w_wrap) begin
        r_cnt <= '0;
        r_ce  <= 1'b1;
        if (r_pend) begin
          // new ratio starts with a fresh low phase so no runt pulse is emitted
          r_div     <= r_pdiv;
          r_pend    <= 1'b0;
          r_out_clk <= 1'b0;
        end else begin
          r_out_clk <= ~r_out_clk;
        end
      end else begin
        r_cnt <= r_cnt + ratio_t'(1);
        r_ce  <= 1'b0;
      end
    end
  end

  assign pend    = r_pend;
  assign ce      = r_ce;
  assign out_clk = r_out_clk;

endmodule

// File: rtl/divclk_ctrl.sv
// Four-channel runtime-programmable clock divider with a valid/ready config port.
module divclk_ctrl #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned DW   = 16,
  parameter int unsigned DIV0 = 2,
  parameter int unsigned DIV1 = 4,
  parameter int unsigned DIV2 = 10,
  parameter int unsigned DIV3 = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [1:0]     cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  output logic [NCH-1:0] ce,
  output logic [NCH-1:0] out_clk,
  output logic [NCH-1:0] pend
);

  import divclk_pkg::*;

  logic [NCH-1:0] w_pend;
  logic [NCH-1:0] w_load;
  logic           w_ready;

  // Ready follows the addressed channel's pending flag; load is the demuxed transfer.
  always_comb begin
    w_ready = !w_pend[cfg_ch];
    w_load  = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      w_load[i] = cfg_valid && w_ready && (cfg_ch == chan_t'(i));
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
    localparam int unsigned RD = (g == 0) ? DIV0 :
                                 (g == 1) ? DIV1 :
                                 (g == 2) ? DIV2 : DIV3;
    divclk_chan #(
      .RST_DIV (ratio_t'(RD))
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[g]),
      .load_div (cfg_div),
      .pend     (w_pend[g]),
      .ce       (ce[g]),
      .out_clk  (out_clk[g])
    );
  end

  assign cfg_ready = w_ready;
  assign pend      = w_pend;

endmodule

// File: tb/tb_divclk_ctrl.sv
// Self-checking bench for divclk_ctrl: per-cycle scoreboard plus hand-derived checkpoint table.
module tb_divclk_ctrl;

  localparam int CE_S   = 0;
  localparam int OUT_S  = 1;
  localparam int PEND_S = 2;
  localparam int RDY_S  = 3;

  typedef struct {
    logic [3:0] ce;
    logic [3:0] oc;
    logic [3:0] pd;
  } exp_t;

  typedef struct {
    int sc;
    int cy;
    int sg;
    int ch;
    bit ex;
  } tv_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  ce;
  logic [3:0]  out_clk;
  logic [3:0]  pend;

  exp_t sbq[$];
  tv_t  tv[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [3:0] h_ce   [0:511];
  logic [3:0] h_out  [0:511];
  logic [3:0] h_pend [0:511];
  logic [3:0] h_rdy  [0:511];

  // Time-anchored reference: next ce of a channel is at anchor + ratio.
  int m_div  [4];
  int m_pdiv [4];
  int m_anc  [4];
  bit m_pend [4];
  bit m_out  [4];
  bit m_ce   [4];
  int def_div[4] = '{2, 4, 10, 100};

  divclk_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .ce        (ce),
    .out_clk   (out_clk),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic add(input int sc, input int cy, input int sg, input int ch, input bit ex);
    tv_t t;
    t.sc = sc; t.cy = cy; t.sg = sg; t.ch = ch; t.ex = ex;
    tv.push_back(t);
  endtask

  task automatic model_edge(input bit r, input bit v, input int ch, input int d, input int t);
    bit acc;
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        m_div[c] = def_div[c]; m_pdiv[c] = 0; m_anc[c] = t;
        m_pend[c] = 1'b0; m_out[c] = 1'b0; m_ce[c] = 1'b0;
      end
    end else begin
      acc = v && !m_pend[ch];
      for (int c = 0; c < 4; c++) begin
        if (m_div[c] == 0) begin
          m_ce[c] = 1'b0;
          m_out[c] = 1'b0;
          if (m_pend[c]) begin
            m_div[c] = m_pdiv[c]; m_pend[c] = 1'b0; m_anc[c] = t;
          end
        end else if (t - m_anc[c] == m_div[c]) begin
          m_ce[c] = 1'b1;
          m_anc[c] = t;
          if (m_pend[c]) begin
            m_div[c] = m_pdiv[c]; m_pend[c] = 1'b0; m_out[c] = 1'b0;
          end else begin
            m_out[c] = !m_out[c];
          end
        end else begin
          m_ce[c] = 1'b0;
        end
      end
      if (acc) begin
        m_pdiv[ch] = d;
        m_pend[ch] = 1'b1;
      end
    end
  endtask

  // One clock: drive inputs, check ready, queue the model result, compare after the edge.
  task automatic tick(input bit r, input bit v, input int ch, input int d);
    exp_t e;
    exp_t g;
    int   nxt;
    rst       = r;
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(d);
    nxt = r ? 0 : cyc + 1;
    #1;
    if (!r) chk($sformatf("cfg_ready c%0d ch%0d", nxt, ch), 32'(cfg_ready), 32'(!m_pend[ch]));
    if (nxt < 512) h_rdy[nxt] = {3'b000, cfg_ready};
    model_edge(r, v, ch, d, nxt);
    for (int c = 0; c < 4; c++) begin
      e.ce[c] = m_ce[c];
      e.oc[c] = m_out[c];
      e.pd[c] = m_pend[c];
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc = nxt;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard empty at c%0d", cyc);
    end else begin
      g = sbq.pop_front();
      chk($sformatf("ce c%0d", cyc), 32'(ce), 32'(g.ce));
      chk($sformatf("out_clk c%0d", cyc), 32'(out_clk), 32'(g.oc));
      chk($sformatf("pend c%0d", cyc), 32'(pend), 32'(g.pd));
    end
    if (cyc < 512) begin
      h_ce[cyc]   = ce;
      h_out[cyc]  = out_clk;
      h_pend[cyc] = pend;
    end
  endtask

  task automatic check_table(input int s);
    logic [3:0] v;
    string      nm;
    foreach (tv[i]) begin
      if (tv[i].sc == s) begin
        case (tv[i].sg)
          CE_S:    begin v = h_ce[tv[i].cy];   nm = "ce";      end
          OUT_S:   begin v = h_out[tv[i].cy];  nm = "out_clk"; end
          PEND_S:  begin v = h_pend[tv[i].cy]; nm = "pend";    end
          default: begin v = h_rdy[tv[i].cy];  nm = "ready";   end
        endcase
        chk($sformatf("s%0d cyc%0d %s[%0d]", s, tv[i].cy, nm, tv[i].ch),
            32'(v[tv[i].ch]), 32'(tv[i].ex));
      end
    end
  endtask

  initial begin
    // scenario 0: reset defaults
    add(0, 1, CE_S, 0, 0);    add(0, 2, CE_S, 0, 1);    add(0, 2, OUT_S, 0, 1);
    add(0, 3, CE_S, 0, 0);    add(0, 4, CE_S, 0, 1);    add(0, 4, OUT_S, 0, 0);
    add(0, 3, CE_S, 1, 0);    add(0, 4, CE_S, 1, 1);    add(0, 8, CE_S, 1, 1);
    add(0, 8, OUT_S, 1, 0);   add(0, 9, CE_S, 2, 0);    add(0, 10, CE_S, 2, 1);
    add(0, 15, OUT_S, 2, 1);  add(0, 20, OUT_S, 2, 0);  add(0, 99, CE_S, 3, 0);
    add(0, 100, CE_S, 3, 1);  add(0, 150, OUT_S, 3, 1); add(0, 200, CE_S, 3, 1);
    add(0, 200, OUT_S, 3, 0); add(0, 399, OUT_S, 3, 1);
    // scenario 1: deferred update on ch1 (4 -> 3)
    add(1, 2, PEND_S, 1, 1);  add(1, 3, PEND_S, 1, 1);  add(1, 4, PEND_S, 1, 0);
    add(1, 4, CE_S, 1, 1);    add(1, 4, OUT_S, 1, 0);   add(1, 6, CE_S, 1, 0);
    add(1, 7, CE_S, 1, 1);    add(1, 7, OUT_S, 1, 1);   add(1, 8, CE_S, 1, 0);
    add(1, 10, CE_S, 1, 1);   add(1, 13, CE_S, 1, 1);   add(1, 10, CE_S, 0, 1);
    add(1, 10, CE_S, 2, 1);   add(1, 3, RDY_S, 0, 0);
    // scenario 2: transfer on the wrap edge of ch0 (2 -> 5)
    add(2, 4, CE_S, 0, 1);    add(2, 4, PEND_S, 0, 1);  add(2, 5, PEND_S, 0, 1);
    add(2, 6, CE_S, 0, 1);    add(2, 6, PEND_S, 0, 0);  add(2, 6, OUT_S, 0, 0);
    add(2, 8, CE_S, 0, 0);    add(2, 10, CE_S, 0, 0);   add(2, 11, CE_S, 0, 1);
    add(2, 11, OUT_S, 0, 1);  add(2, 16, CE_S, 0, 1);   add(2, 16, OUT_S, 0, 0);
    // scenario 3: ch2 off then N=1
    add(3, 3, PEND_S, 2, 1);  add(3, 9, PEND_S, 2, 1);  add(3, 10, CE_S, 2, 1);
    add(3, 10, OUT_S, 2, 0);  add(3, 10, PEND_S, 2, 0); add(3, 20, CE_S, 2, 0);
    add(3, 24, OUT_S, 2, 0);  add(3, 25, PEND_S, 2, 1); add(3, 26, PEND_S, 2, 0);
    add(3, 26, CE_S, 2, 0);   add(3, 27, CE_S, 2, 1);   add(3, 27, OUT_S, 2, 1);
    add(3, 28, CE_S, 2, 1);   add(3, 28, OUT_S, 2, 0);  add(3, 30, CE_S, 2, 1);
    // scenario 4: back-pressure on ch3, ch0 slips through
    add(4, 5, PEND_S, 3, 1);  add(4, 49, PEND_S, 3, 1); add(4, 50, PEND_S, 0, 1);
    add(4, 50, PEND_S, 3, 1); add(4, 99, PEND_S, 3, 1); add(4, 100, CE_S, 3, 1);
    add(4, 100, PEND_S, 3, 0); add(4, 101, PEND_S, 3, 1); add(4, 107, CE_S, 3, 1);
    add(4, 107, PEND_S, 3, 0); add(4, 109, CE_S, 3, 0); add(4, 114, CE_S, 3, 0);
    add(4, 116, CE_S, 3, 1);  add(4, 52, PEND_S, 0, 0); add(4, 54, CE_S, 0, 0);
    add(4, 55, CE_S, 0, 1);   add(4, 6, RDY_S, 0, 0);   add(4, 50, RDY_S, 0, 1);
    add(4, 100, RDY_S, 0, 0); add(4, 101, RDY_S, 0, 1);
    // scenario 5: reset mid-operation
    add(5, 0, PEND_S, 1, 0);  add(5, 0, PEND_S, 2, 0);  add(5, 0, OUT_S, 0, 0);
    add(5, 0, CE_S, 0, 0);    add(5, 2, CE_S, 0, 1);    add(5, 4, CE_S, 1, 1);
    add(5, 4, OUT_S, 1, 1);   add(5, 5, CE_S, 2, 0);    add(5, 9, CE_S, 2, 0);
    add(5, 10, CE_S, 2, 1);   add(5, 99, CE_S, 3, 0);   add(5, 100, CE_S, 3, 1);

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;

    // scenario 0
    tick(1, 0, 0, 0);
    repeat (400) tick(0, 0, 0, 0);
    check_table(0);

    // scenario 1
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 1, 1, 3);
    repeat (18) tick(0, 0, 1, 0);
    check_table(1);

    // scenario 2
    tick(1, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0);
    tick(0, 1, 0, 5);
    repeat (16) tick(0, 0, 0, 0);
    check_table(2);

    // scenario 3
    tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 2, 0);
    tick(0, 1, 2, 0);
    repeat (21) tick(0, 0, 2, 0);
    tick(0, 1, 2, 1);
    repeat (7) tick(0, 0, 2, 0);
    check_table(3);

    // scenario 4
    tick(1, 0, 0, 0);
    repeat (4) tick(0, 0, 3, 0);
    tick(0, 1, 3, 7);
    for (int t = 6; t <= 101; t++) begin
      if (t == 50) tick(0, 1, 0, 3);
      else         tick(0, 1, 3, 9);
    end
    repeat (19) tick(0, 0, 3, 0);
    check_table(4);

    // scenario 5
    tick(1, 0, 0, 0);
    repeat (5) tick(0, 0, 0, 0);
    tick(0, 1, 1, 7);
    chk("pre-reset pend[1]", 32'(pend[1]), 32'd1);
    tick(1, 1, 2, 5);
    repeat (110) tick(0, 0, 0, 0);
    check_table(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divclk_ctrl.md
# divclk_ctrl

Runtime-programmable controller for the four-output clock divider stage of the DDS datapath. It sits between the system clock and the phase-accumulator and DAC update logic. It holds a per-channel divide ratio and generates one-cycle clock-enable pulses plus 50%-duty divided clocks. New ratios are accepted over a valid/ready port and applied glitch-free only at the current period boundary.

## Interface
Parameters:
- NCH, 4, number of divider channels (fixed at 4 in this design)
- DW, 16, divide-ratio width
- DIV0, 2, reset ratio of channel 0
- DIV1, 4, reset ratio of channel 1
- DIV2, 10, reset ratio of channel 2
- DIV3, 100, reset ratio of channel 3

Ports:
- clk  in  1  system clock, 100 MHz; the only clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config request valid
- cfg_ready  out  1  config request can be accepted
- cfg_ch  in  2  target channel
- cfg_div  in  DW  new ratio N; 0 = channel off
- ce  out  NCH  per-channel one-cycle enable pulse, one every N cycles
- out_clk  out  NCH  per-channel divided clock, period 2N cycles, toggles on each ce
- pend  out  NCH  per-channel "ratio update pending" status

## Operation
- Each channel has a counter cnt (DW bits), an active ratio div, and a pending register pdiv with flag pend.
- N ≥ 1, running: cnt counts 0..N-1. At the edge where cnt==N-1: cnt←0, ce high for the following cycle, out_clk toggles. N=1 gives ce high every cycle and out_clk toggling every cycle.
- N = 0 (off): cnt held at 0, ce=0, out_clk forced 0.
- Handshake: cfg_ready = !pend[cfg_ch] (combinational on cfg_ch). A transfer happens on a clock edge with cfg_valid && cfg_ready. On transfer: pdiv[cfg_ch]←cfg_div, pend[cfg_ch]←1.
- Apply rule, running channel: at a wrap edge with pend already 1 before that edge, div←pdiv, pend←0, cnt←0, out_clk←0. The new period starts in the next cycle. A transfer landing on the same edge as a wrap applies at the following wrap.
- Apply rule, off channel: a pending ratio applies on the edge after acceptance, and cnt starts from 0.
- Writing 0 to a running channel stops it only at its next wrap. No truncated period and no runt out_clk pulse.
- Writing the ratio already active is a normal update: it still waits for a wrap and resets out_clk phase.
- Channels are independent. Only the config port is shared, one transfer per cycle.

## Timing
- Reset (rst high at an edge): cnt=0, div=DIVn, pend=0, ce=0, out_clk=0 on every channel. Applies mid-period and mid-handshake; a transfer presented in the rst cycle is dropped.
- After rst deasserts, the first ce for ratio N is high in cycle N (cycle 1 = first edge with rst low). out_clk first rises in the same cycle.
- ce and out_clk are registered outputs with no combinational path from inputs. pend is registered. cfg_ready is combinational from pend and cfg_ch only.
- Update latency, running channel: from acceptance to first ce at the new ratio M = (cycles remaining to wrap) + M.
- Ratio arithmetic is unsigned DW-bit. The comparison uses cnt == div-1 with div ≥ 1; no overflow is possible.

## Structure
- Shared package divclk_pkg:
  - NCH and DW constants
  - DIV_OFF = 0
  - channel index type (2-bit)
  - ratio type (DW-bit)
- Sub-module divclk_chan, instantiated NCH times:
  - contains cnt, div, pdiv, pend, the apply rule, ce and out_clk
  - ports: clk, rst, load, load_div, pend, ce, out_clk, plus the reset ratio as a parameter
- Top level holds only the cfg_ch demux, load generation and the cfg_ready mux.

## Test plan
- Reset defaults: release rst, run 400 cycles. ce[0..3] period = 2/4/10/100 cycles, first ce in cycles 2/4/10/100; out_clk periods 4/8/20/200 at 50% duty.
- Deferred update: channel 1 running at N=4; accept cfg_div=3 when cnt=1. pend[1]=1 and cfg_ready=0 for ch1 until the wrap; the next ce comes 2 cycles later, then every 3 cycles. ch0/2/3 are undisturbed.
- Wrap collision: accept ch0 cfg_div=5 on the exact wrap edge. The old ratio 2 is kept for one more period, then period 5.
- Off/on: write 0 to ch2 (N=10). It stops after its current wrap with out_clk=0. Then write 1: ce is high every cycle starting 2 cycles after acceptance.
- Back-pressure: hold cfg_valid with ch3 while pend[3]=1. No second transfer until the ch3 wrap; a ch0 request in the meantime is accepted immediately.
- Reset mid-operation: assert rst for 1 cycle mid-period with pend[1]=1. Next cycle all outputs are 0 and pend is cleared, and the channels restart at default ratios with the timing of the first scenario.
